uart_tx_serializer: RTL and testbench

- Transmit end of the peripheral UART path.
- Accepts one byte from the memory-mapped peripheral block (its UART_TXD register plus a one-cycle start strobe) and serializes it onto the TX pin as 8N1: start bit, 8 data bits LSB first, stop bit.
- Reports status back to that block: tx_status (ready/busy) feeds UART_CON[4]; tx_end is a one-cycle completion pulse that sets UART_CON[2].

---
 rtl/uart_tx_serializer.sv | 117 +++++++++++
 tb/tb_uart_tx_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one byte in, 8N1 frame out (LSB first), BIT_DIV clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_serializer #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 9600,
    parameter int BIT_DIV   = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       uart_tx,
    output logic       tx_status,
    output logic       tx_end
);

    localparam int CNT_W = $clog2(BIT_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic [2:0]       state, state_d;
    logic [CNT_W-1:0] baud_cnt, cnt_d;
    logic [2:0]       bit_idx, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_d, status_d, end_d;
    logic             bit_end, accept;

    assign bit_end = (baud_cnt == CNT_LAST);
    // tx_status is also high in the last stop cycle, which is what lets frames run back to back.
    assign accept  = tx_start && tx_status;

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;
    assign parity_d = accept ? ^tx_data : parity_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_q <= 1'b0;
        else        parity_q <= parity_d;
    end
`endif

    always_comb begin
        state_d = state;
        cnt_d   = bit_end ? '0 : baud_cnt + 1'b1;
        bit_d   = bit_idx;
        shift_d = shift_q;
        case (state)
            IDLE: cnt_d = '0;
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = 3'd0;
            end
            DATA: if (bit_end) begin
                shift_d = {1'b0, shift_q[7:1]};
                bit_d   = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_d = AFTER_DATA;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: if (bit_end) state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            state_d = START;
            cnt_d   = '0;
            bit_d   = 3'd0;
            shift_d = tx_data;
        end

        // Outputs are decoded from next-state so the registered pins line up with the state.
        end_d    = (state_d == STOP) && (cnt_d == CNT_LAST);
        status_d = (state_d == IDLE) || end_d;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift_q   <= 8'd0;
            uart_tx   <= 1'b1;
            tx_status <= 1'b1;
            tx_end    <= 1'b0;
        end else begin
            state     <= state_d;
            baud_cnt  <= cnt_d;
            bit_idx   <= bit_d;
            shift_q   <= shift_d;
            uart_tx   <= tx_d;
            tx_status <= status_d;
            tx_end    <= end_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: stimulus queues expected bytes, a line monitor decodes frames and compares.
module tb_uart_tx_serializer;

    localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       uart_tx, tx_status, tx_end;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pos = -1;
    int mon_start_cyc = 0;
    logic [NB-1:0] samp;
    logic [7:0] exp_q[$];

    uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .uart_tx(uart_tx), .tx_status(tx_status), .tx_end(tx_end)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Line monitor: finds a start bit, samples every bit mid-way, checks tx_end timing and payload.
    always @(negedge clk) begin
        if (!reset) begin
            pos = -1;
        end else begin
            if (pos < 0 && uart_tx == 1'b0) begin
                pos = 0;
                mon_start_cyc = cyc;
            end
            if (pos >= 0) begin
                if (pos % BD == BD / 2) samp[pos / BD] = uart_tx;
                if (pos == NB * BD - 1) begin
                    chk("end_pulse", {31'd0, tx_end}, 1);
                    chk("end_status", {31'd0, tx_status}, 1);
                    chk("start_bit", {31'd0, samp[0]}, 0);
                    chk("stop_bit", {31'd0, samp[NB-1]}, 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", {24'd0, samp[8:1]}, 32'hFFFF_FFFF);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        chk("data_byte", {24'd0, samp[8:1]}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", {31'd0, samp[9]}, $countones(e) % 2);
`endif
                    end
                    pos = -1;
                end else begin
                    if (tx_end) chk("stray_end", {31'd0, tx_end}, 0);
                    pos++;
                end
            end else if (tx_end) begin
                chk("stray_end", {31'd0, tx_end}, 0);
            end
        end
    end

    // All tasks start and return at a negedge.
    task automatic wait_ready();
        int n = 0;
        while (!tx_status && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!tx_status) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!tx_end && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!tx_end) chk("end_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] b, input bit expect_it);
        wait_ready();
        tx_start = 1'b1;
        tx_data  = b;
        if (expect_it) exp_q.push_back(b);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        chk("busy_after_accept", {31'd0, tx_status}, 0);
        chk("line_low_after_accept", {31'd0, uart_tx}, 0);
        @(negedge clk);
    endtask

    task automatic poke_busy(input logic [7:0] b);
        chk("busy_before_poke", {31'd0, tx_status}, 0);
        tx_start = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic b2b(input logic [7:0] b);
        int e;
        wait_end();
        e = cyc;
        send(b, 1);
        @(negedge clk);
        chk("b2b_gap", mon_start_cyc, e + 1);
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("rst_uart_tx", {31'd0, uart_tx}, 1);
        chk("rst_status", {31'd0, tx_status}, 1);
        chk("rst_end", {31'd0, tx_end}, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // single frame
        send(8'hA5, 1);
        wait_ready();

        // busy rejection: second request ~40 cycles into the frame
        send(8'h0F, 1);
        repeat (38) @(negedge clk);
        poke_busy(8'hFF);

        // back-to-back
        b2b(8'h55);
        wait_ready();
        repeat (3) @(negedge clk);

        // async reset during data bit 3
        send(8'h3C, 0);
        repeat (4 * BD + BD / 2 - 1) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_uart_tx", {31'd0, uart_tx}, 1);
        chk("midrst_status", {31'd0, tx_status}, 1);
        chk("midrst_end", {31'd0, tx_end}, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        send(8'h81, 1);
        wait_ready();

        // tx_data churn during a frame
        send(8'hC3, 1);
        repeat (NB * BD) begin
            tx_data = 8'($urandom);
            @(negedge clk);
        end

        // parity-relevant patterns (plain data checks without the parity build)
        send(8'h07, 1);
        send(8'h03, 1);

        // randomized mix
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            int mode;
            b = 8'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 1 && !tx_status) begin
                b2b(b);
            end else begin
                send(b, 1);
                if (mode == 2) begin
                    repeat ($urandom_range(1, 140)) @(negedge clk);
                    poke_busy(8'($urandom));
                end else begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        end

        wait_ready();
        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
